score_segment_driver: RTL and testbench

- Sequential source end of the score display path: holds both players' scores and drives the seven segment lines (a..g) that the score video renderer consumes.
- Counts points from miss pulses, detects game over, and selects which digit's segments are presented from the current beam position.
- Sits between the game logic (ball/miss detection, start control) and the score renderer. Runs on the pixel clock.

---
 rtl/score_segment_driver.sv | 141 ++++++++++++++
 tb/tb_score_segment_driver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/score_segment_driver.sv
// Score keeper and seven-segment source for the score renderer: counts points
// from miss edges, flags game over, and presents the digit under the beam.
// Optional: SCORE_TENS_BLANK_EN blanks a tens digit of 0.
module score_segment_driver #(
    parameter int         WIN_SCORE = 11,
    parameter logic [3:0] SLOT_LT   = 4'd4,
    parameter logic [3:0] SLOT_LU   = 4'd5,
    parameter logic [3:0] SLOT_RT   = 4'd10,
    parameter logic [3:0] SLOT_RU   = 4'd11,
    parameter logic [2:0] VROW      = 3'd1
) (
    input  logic       clk7_159,
    input  logic       rst_n,
    input  logic [8:0] hcnt,
    input  logic [7:0] vcnt,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic       new_game,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       game_over,
    output logic [4:0] score_l,
    output logic [4:0] score_r
);

    localparam logic [4:0] WIN_BCD = {1'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    // Index 0 is the left player (scored by miss_right), index 1 the right.
    logic [1:0]      miss_raw, miss_q, miss_qq, hit;
    logic [1:0][4:0] score;
    logic [3:0]      slot;
    logic [3:0]      digit;
    logic            vis, blank;
    logic [6:0]      seg_q;
    logic            unused_bits;

    assign miss_raw    = {miss_left, miss_right};
    assign hit         = miss_q & ~miss_qq;
    assign slot        = hcnt[8:5];
    assign unused_bits = ^{hcnt[4:0], vcnt[4:0]};

    function automatic logic [4:0] bcd_inc(input logic [4:0] s);
        if (s[3:0] == 4'd9) return 5'b1_0000;
        return {s[4], s[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // History starts high so a miss held through reset release never scores.
    always_ff @(posedge clk7_159) begin
        if (!rst_n) begin
            miss_q  <= '1;
            miss_qq <= '1;
        end else begin
            miss_q  <= miss_raw;
            miss_qq <= miss_q;
        end
    end

    always_ff @(posedge clk7_159) begin
        if (!rst_n || new_game) begin
            score <= '0;
        end else begin
            for (int p = 0; p < 2; p++)
                if (hit[p] && !game_over && score[p] != WIN_BCD)
                    score[p] <= bcd_inc(score[p]);
        end
    end

    always_ff @(posedge clk7_159) begin
        if (!rst_n || new_game)
            game_over <= 1'b0;
        else if (score[0] == WIN_BCD || score[1] == WIN_BCD)
            game_over <= 1'b1;
    end

    assign score_l = score[0];
    assign score_r = score[1];

    always_comb begin
        digit = 4'd0;
        vis   = 1'b0;
        blank = 1'b0;
        if (vcnt[7:5] == VROW) begin
            case (slot)
                SLOT_LT: begin
                    vis   = 1'b1;
                    digit = {3'b000, score[0][4]};
`ifdef SCORE_TENS_BLANK_EN
                    blank = !score[0][4];
`endif
                end
                SLOT_LU: begin
                    vis   = 1'b1;
                    digit = score[0][3:0];
                end
                SLOT_RT: begin
                    vis   = 1'b1;
                    digit = {3'b000, score[1][4]};
`ifdef SCORE_TENS_BLANK_EN
                    blank = !score[1][4];
`endif
                end
                SLOT_RU: begin
                    vis   = 1'b1;
                    digit = score[1][3:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk7_159) begin
        if (!rst_n)
            seg_q <= '0;
        else
            seg_q <= (vis && !blank) ? seg7(digit) : 7'b0000000;
    end

    assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_score_segment_driver.sv
// Scoreboard bench for score_segment_driver: stimulus queues cycle-stamped
// expectations, a negedge monitor compares them against the DUT outputs.
module tb_score_segment_driver;

    logic       clk7_159 = 1'b0;
    logic       rst_n, miss_left, miss_right, new_game;
    logic [8:0] hcnt;
    logic [7:0] vcnt;
    logic       a, b, c, d, e, f, g, game_over;
    logic [4:0] score_l, score_r;

    score_segment_driver dut (
        .clk7_159(clk7_159), .rst_n(rst_n), .hcnt(hcnt), .vcnt(vcnt),
        .miss_left(miss_left), .miss_right(miss_right), .new_game(new_game),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .game_over(game_over), .score_l(score_l), .score_r(score_r)
    );

    always #5 clk7_159 = ~clk7_159;

    localparam int K_SL = 0, K_SR = 1, K_GO = 2, K_SEG = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic [6:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

`ifdef SCORE_TENS_BLANK_EN
    localparam logic [6:0] TENS0 = 7'b0000000;
`else
    localparam logic [6:0] TENS0 = 7'b1111110;
`endif

    always @(posedge clk7_159) cyc <= cyc + 1;

    function automatic logic [6:0] actual(input int kind);
        case (kind)
            K_SL:    return {2'b00, score_l};
            K_SR:    return {2'b00, score_r};
            K_GO:    return {6'b0, game_over};
            default: return {a, b, c, d, e, f, g};
        endcase
    endfunction

    function automatic logic [6:0] bcd(input int n);
        logic [4:0] v;
        v = {(n >= 10), 4'(n % 10)};
        return {2'b00, v};
    endfunction

    always @(negedge clk7_159) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                n_tests++;
                if (actual(sb[i].kind) !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got=%b want=%b", sb[i].name, cyc,
                             actual(sb[i].kind), sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s stale expectation cyc=%0d now=%0d", sb[i].name, sb[i].cyc, cyc);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk7_159);
        #2;
    endtask

    task automatic push(input int dc, input int kind, input logic [6:0] v, input string nm);
        exp_t x;
        x.cyc  = cyc + dc;
        x.kind = kind;
        x.val  = v;
        x.name = nm;
        sb.push_back(x);
    endtask

    // Raise the chosen miss lines for `hold` cycles; scores land 2 cycles after the rise.
    task automatic pulse(input bit ml, input bit mr, input int hold,
                         input int el, input int er, input string nm);
        miss_left  = ml;
        miss_right = mr;
        push(2, K_SL, bcd(el), {nm, "_l"});
        push(2, K_SR, bcd(er), {nm, "_r"});
        repeat (hold) tick();
        miss_left  = 1'b0;
        miss_right = 1'b0;
        tick();
        tick();
    endtask

    task automatic beam(input int s, input int row, input logic [6:0] v, input string nm);
        hcnt = 9'(s * 32 + 7);
        vcnt = 8'(row * 32 + 3);
        push(1, K_SEG, v, nm);
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; miss_left = 1'b1; miss_right = 1'b0; new_game = 1'b0;
        hcnt = 9'd0; vcnt = 8'd0;
        tick();
        push(0, K_SL, 7'd0, "rst_sl");
        push(0, K_SR, 7'd0, "rst_sr");
        push(0, K_GO, 7'd0, "rst_go");
        push(0, K_SEG, 7'd0, "rst_seg");
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) push(i, K_SR, 7'd0, "held_through_reset");
        push(4, K_GO, 7'd0, "go_after_rst");
        repeat (4) tick();
        miss_left = 1'b0;
        repeat (3) tick();
        push(1, K_SR, 7'd0, "rise_lat1");
        pulse(1'b1, 1'b0, 1, 0, 1, "rise_lat2");

        for (int i = 1; i <= 10; i++) pulse(1'b0, 1'b1, 1, i, 1, "ten_right");
        beam(5, 1, 7'b1111110, "lu_zero");
        beam(4, 1, 7'b0110000, "lt_one");
        beam(11, 1, 7'b0110000, "ru_one");
        beam(10, 1, TENS0, "rt_zero");

        for (int i = 2; i <= 10; i++) pulse(1'b1, 1'b0, 1, 10, i, "to_win");
        push(2, K_GO, 7'd0, "go_not_yet");
        push(3, K_GO, 7'd1, "go_set");
        pulse(1'b1, 1'b0, 1, 10, 11, "win");
        pulse(1'b1, 1'b0, 1, 10, 11, "past_win");
        pulse(1'b0, 1'b1, 1, 10, 11, "after_go");
        beam(10, 1, 7'b0110000, "rt_one");
        beam(11, 1, 7'b0110000, "ru_one_win");

        new_game = 1'b1;
        push(1, K_SL, 7'd0, "ng_sl");
        push(1, K_SR, 7'd0, "ng_sr");
        push(1, K_GO, 7'd0, "ng_go");
        tick();
        new_game = 1'b0;
        tick();
        for (int i = 1; i <= 3; i++) pulse(1'b1, 1'b1, 1, i, i, "both");
        pulse(1'b1, 1'b1, 1, 4, 4, "both_4");

        miss_left = 1'b1; miss_right = 1'b1; new_game = 1'b1;
        push(2, K_SL, 7'd0, "ng_pri_l");
        push(2, K_SR, 7'd0, "ng_pri_r");
        push(4, K_SL, 7'd0, "ng_drop_l");
        push(4, K_SR, 7'd0, "ng_drop_r");
        push(4, K_GO, 7'd0, "ng_drop_go");
        tick();
        tick();
        new_game = 1'b0;
        tick();
        miss_left = 1'b0; miss_right = 1'b0;
        repeat (3) tick();

        for (int i = 1; i <= 7; i++) pulse(1'b0, 1'b1, 1, i, 0, "to_seven");
        beam(4, 1, TENS0, "lt_tens0");
        beam(5, 1, 7'b1110000, "lu_seven");
        beam(6, 1, 7'b0000000, "non_slot");
        beam(5, 2, 7'b0000000, "wrong_row");
        beam(11, 1, 7'b1111110, "ru_zero");

        push(101, K_SL, bcd(8), "hold_mid");
        push(104, K_SL, bcd(8), "hold_after");
        pulse(1'b0, 1'b1, 100, 8, 0, "hold100");
        beam(5, 1, 7'b1111111, "lu_eight");
        repeat (4) tick();

        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
